// File: rtl/child_sweep_sequencer_pkg.sv
// child_seq_pkg: shared state encoding, default sizes and index-width helper for the sweep sequencer
package child_seq_pkg;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} seq_state_e;
   localparam int NUM_CHILD_DEF = 10;
   localparam int TIMEOUT_DEF = 200;
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/child_sweep_sequencer_lowest_set_idx.sv
// lowest_set_idx: priority encoder returning the lowest set bit index and an any-set flag
module lowest_set_idx #(
   parameter int N = 10,
   parameter int W = 4
) (
   input  logic [N-1:0] i_mask,
   output logic [W-1:0] o_idx,
   output logic         o_any
);
   // scan from the top so the lowest set bit is the last one written
   always_comb begin
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--) o_idx = i_mask[i] ? W'(i) : o_idx;
      o_any = |i_mask;
   end
endmodule

// File: rtl/child_sweep_sequencer.sv
// child_sweep_sequencer: starts each enabled child in ascending order, waits for done or timeout, reports timeouts
module child_sweep_sequencer
   import child_seq_pkg::*;
#(
   parameter int NUM_CHILD = NUM_CHILD_DEF,
   parameter int TIMEOUT_W = 8,
   parameter int TIMEOUT = TIMEOUT_DEF,
   localparam int IDX_W = idx_w(NUM_CHILD)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   input  logic [NUM_CHILD-1:0] cmd_mask,
   output logic                 cmd_ready,
   input  logic                 abort,
   output logic [NUM_CHILD-1:0] child_start,
   input  logic [NUM_CHILD-1:0] child_done,
   output logic                 busy,
   output logic [IDX_W-1:0]     cur_idx,
   output logic [NUM_CHILD-1:0] timeout_mask,
   output logic                 sweep_done
);
   seq_state_e           r_state;
   logic [IDX_W-1:0]     r_idx, w_idx;
   logic [NUM_CHILD-1:0] r_rem, r_tmask, w_bit, w_rem_clr, w_enc_in;
   logic [TIMEOUT_W-1:0] r_cnt;
   logic                 r_done, w_any, w_hit, w_to;

   assign w_bit        = NUM_CHILD'(1) << r_idx;
   assign w_rem_clr    = r_rem & ~w_bit;
   assign w_enc_in     = (r_state == IDLE) ? cmd_mask : w_rem_clr;
   assign w_hit        = child_done[r_idx];
   assign w_to         = r_cnt == TIMEOUT_W'(TIMEOUT - 1);
   assign cmd_ready    = r_state == IDLE;
   assign busy         = r_state != IDLE;
   assign child_start  = (r_state == LAUNCH) ? w_bit : '0;
   assign cur_idx      = r_idx;
   assign timeout_mask = r_tmask;
   assign sweep_done   = r_done;

   lowest_set_idx #(.N(NUM_CHILD), .W(IDX_W)) u_enc (
      .i_mask(w_enc_in),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   // sweep FSM: accept, launch one child, wait for its done or timeout, then advance or finish
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_rem   <= '0;
         r_tmask <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (cmd_valid) begin
               r_rem   <= cmd_mask;
               r_tmask <= '0;
               r_idx   <= w_idx;
               r_state <= w_any ? LAUNCH : FINISH;
               r_done  <= !w_any;
            end
            LAUNCH: begin
               r_cnt   <= '0;
               r_state <= abort ? FINISH : WAIT;
               r_done  <= abort;
               if (abort) r_rem <= '0;
            end
            WAIT: if (w_hit || w_to || abort) begin
               r_rem <= abort ? '0 : w_rem_clr;
               if (w_to && !w_hit) r_tmask <= r_tmask | w_bit;
               if (!abort && w_any) begin
                  r_idx   <= w_idx;
                  r_state <= LAUNCH;
               end else begin
                  r_state <= FINISH;
                  r_done  <= 1'b1;
               end
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            FINISH: begin
               r_done  <= 1'b0;
               r_idx   <= '0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_child_sweep_sequencer.sv
// tb_child_sweep_sequencer: randomized scoreboard bench for the child sweep sequencer
module tb_child_sweep_sequencer;
   import child_seq_pkg::*;
   localparam int N  = 10;
   localparam int TW = 8;
   localparam int TO = 6;
   localparam int IW = idx_w(N);

   logic          clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, abort = 1'b0;
   logic [N-1:0]  cmd_mask = '0, child_done = '0;
   logic          cmd_ready, busy, sweep_done;
   logic [N-1:0]  child_start, timeout_mask;
   logic [IW-1:0] cur_idx;

   child_sweep_sequencer #(.NUM_CHILD(N), .TIMEOUT_W(TW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_mask(cmd_mask), .cmd_ready(cmd_ready),
      .abort(abort), .child_start(child_start), .child_done(child_done), .busy(busy),
      .cur_idx(cur_idx), .timeout_mask(timeout_mask), .sweep_done(sweep_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {bit fin; int idx; int c; logic [N-1:0] tm;} ev_t;
   ev_t exp_q[$];
   int checks = 0, errors = 0;

   // per-sweep child behaviour: dly 0 = never responds, else done seen dly edges after the start edge
   int           dly[N];
   bit           early[N];
   logic [N-1:0] stray_g = '0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h at cycle %0d", nm, act, req, cyc);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, cmd_ready, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_child_start"}, child_start, 0);
      check({tag, "_cur_idx"}, cur_idx, 0);
      check({tag, "_timeout_mask"}, timeout_mask, 0);
      check({tag, "_sweep_done"}, sweep_done, 0);
   endtask

   // monitor: every start pulse or sweep_done is matched against the next expected event
   always @(negedge clk) begin
      ev_t e;
      if (!rst && (child_start != '0 || sweep_done)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", {child_start, sweep_done}, 0);
         end else begin
            e = exp_q.pop_front();
            if (e.fin) begin
               check("sweep_done", sweep_done, 1);
               check("done_cycle", cyc, e.c);
               check("done_timeout_mask", timeout_mask, e.tm);
               check("done_no_start", child_start, 0);
            end else begin
               check("start_vec", child_start, N'(1) << e.idx);
               check("start_cycle", cyc, e.c);
               check("start_cur_idx", cur_idx, e.idx);
               check("start_no_done", sweep_done, 0);
            end
         end
      end
   end

   // issue one sweep: model the expected event timeline, then drive the children and abort to match it
   task automatic run_sweep(input logic [N-1:0] mask, input int ab_rel, input int rst_rel);
      logic [N-1:0] dv[512];
      logic [N-1:0] tm;
      int t, e, a, fin;
      bit stop, hit;
      for (int i = 0; i < 512; i++) dv[i] = '0;
      @(negedge clk);
      a = cyc + 1;
      cmd_valid = 1'b1;
      cmd_mask = mask;
      child_done = '0;
      abort = 1'b0;
      t = 0;
      tm = '0;
      stop = 0;
      for (int k = 0; k < N; k++) begin
         if (!stop && mask[k]) begin
            exp_q.push_back('{0, k, a + t, '0});
            if (early[k]) dv[t + 1][k] = 1'b1;
            if (ab_rel == t + 1) begin
               stop = 1;
               t = t + 1;
            end else begin
               hit = dly[k] != 0 && dly[k] <= TO;
               e = t + 1 + (hit ? dly[k] : TO);
               if (dly[k] != 0) dv[t + 1 + dly[k]][k] = 1'b1;
               if (ab_rel > t + 1 && ab_rel < e) begin
                  stop = 1;
                  t = ab_rel;
               end else begin
                  if (!hit) tm[k] = 1'b1;
                  t = e;
                  if (ab_rel == e) stop = 1;
               end
            end
         end
      end
      fin = t;
      exp_q.push_back('{1, 0, a + fin, tm});
      for (int r = 1; r <= fin + 1; r++) dv[r] |= (N'($urandom) | stray_g) & ~mask;
      for (int r = 1; r <= fin + 1; r++) begin
         @(negedge clk);
         if (r == rst_rel) begin
            check("tm_before_reset", timeout_mask, tm & ((N'(1) << cur_idx) - 1));
            #2 rst = 1'b1;
            #1 check_reset_outputs("async_reset");
            exp_q.delete();
            cmd_valid = 1'b0;
            child_done = '0;
            abort = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check_reset_outputs("held_reset");
            rst = 1'b0;
            return;
         end
         child_done = dv[r];
         abort = r == ab_rel;
         if (r <= fin) cmd_mask = N'($urandom);
         else cmd_valid = 1'b0;
      end
      @(negedge clk);
      child_done = '0;
      abort = 1'b0;
      check("end_cmd_ready", cmd_ready, 1);
      check("end_busy", busy, 0);
      check("end_cur_idx", cur_idx, 0);
      check("end_timeout_mask_held", timeout_mask, tm);
      check("end_events_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic set_all(input int d, input bit er);
      for (int k = 0; k < N; k++) begin
         dly[k] = d;
         early[k] = er;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      // ascending order with a fixed response delay
      set_all(4, 0);
      run_sweep(10'b0000000101, -1, -1);
      // empty mask finishes straight away
      run_sweep('0, -1, -1);
      // silent top child times out
      set_all(0, 0);
      run_sweep(10'b1000000000, -1, -1);
      // stray done from child 3 and an early done during launch are both ignored
      early[1] = 1;
      stray_g = 10'b0000001000;
      run_sweep(10'b0000000010, -1, -1);
      stray_g = '0;
      // done on the timeout cycle wins
      set_all(TO, 0);
      run_sweep(10'b0000000010, -1, -1);
      // abort while waiting on child 2
      set_all(2, 0);
      run_sweep(10'h3FF, 8, -1);
      // random sweeps
      for (int s = 0; s < 60; s++) begin
         for (int k = 0; k < N; k++) begin
            dly[k] = $urandom_range(TO + 2, 0);
            early[k] = $urandom_range(1, 0) == 1;
         end
         run_sweep(($urandom_range(7, 0) == 0) ? '0 : N'($urandom),
                   ($urandom_range(3, 0) == 0) ? int'($urandom_range(40, 1)) : -1, -1);
      end
      // asynchronous reset while child 4 is awaited after child 3 timed out
      set_all(0, 0);
      run_sweep(10'b0000011000, -1, 10);
      set_all(1, 0);
      run_sweep(10'b0000010001, -1, -1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end
endmodule
